// File: rtl/mem_pkg.sv
// Shared definitions for the miniRV memory stage: write-back source codes,
// FSM state type and bus-timeout sizing.
package mem_pkg;

  localparam logic [1:0] RF_WSEL_ALU = 2'b00;
  localparam logic [1:0] RF_WSEL_RAM = 2'b01;
  localparam logic [1:0] RF_WSEL_PC4 = 2'b10;
  localparam logic [1:0] RF_WSEL_IMM = 2'b11;

  localparam int unsigned TIMEOUT_CYCLES = 255;
  localparam int unsigned TMO_CNT_W      = 8;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } mem_state_e;

endpackage

// File: rtl/reg_mem_wb.sv
// MEM/WB pipeline register: async active-low reset; a bubble clears the
// valid/write-enable bits while data and index hold their previous values.
module reg_mem_wb
  import mem_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        bubble_i,
  input  logic        valid_i,
  input  logic        rf_we_i,
  input  logic [4:0]  wR_i,
  input  logic [31:0] wD_i,
  output logic        wb_valid_o,
  output logic        wb_rf_we_o,
  output logic [4:0]  wb_wR_o,
  output logic [31:0] wb_wD_o
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wb_valid_o <= 1'b0;
      wb_rf_we_o <= 1'b0;
      wb_wR_o    <= '0;
      wb_wD_o    <= '0;
    end else if (bubble_i) begin
      wb_valid_o <= 1'b0;
      wb_rf_we_o <= 1'b0;
    end else begin
      wb_valid_o <= valid_i;
      wb_rf_we_o <= valid_i & rf_we_i;
      wb_wR_o    <= wR_i;
      wb_wD_o    <= wD_i;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// miniRV memory stage: req/ack word load/store with upstream stall, write-back
// select and MEM/WB register. Define MEM_TIMEOUT_EN for the bus-ack timeout.
module mem_wb_stage
  import mem_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        valid_i,
  input  logic [31:0] wD_i,
  input  logic [4:0]  wR_i,
  input  logic [1:0]  rf_wsel_i,
  input  logic        rf_we_i,
  input  logic        ram_we_i,
  input  logic [31:0] rD2_i,
  input  logic [31:0] aluc_i,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [31:0] dbus_wdata_o,
  input  logic        dbus_ack_i,
  input  logic [31:0] dbus_rdata_i,
  output logic        stall_o,
  output logic        wb_valid_o,
  output logic [31:0] wb_wD_o,
  output logic [4:0]  wb_wR_o,
  output logic        wb_rf_we_o,
  output logic        err_o
);

  mem_state_e  state_q, state_d;
  logic        is_load, acc, tmo, stall;
  logic [31:0] wb_data;
  logic        aluc_lo_unused;

  assign is_load        = (rf_wsel_i == RF_WSEL_RAM);
  assign acc            = valid_i & (ram_we_i | is_load);
  assign aluc_lo_unused = ^aluc_i[1:0];

`ifdef MEM_TIMEOUT_EN
  logic [TMO_CNT_W-1:0] wait_q;
  logic                 err_q;

  assign tmo   = (state_q == REQ) & ~dbus_ack_i
               & (wait_q == TMO_CNT_W'(TIMEOUT_CYCLES - 1));
  assign err_o = err_q;

  // Counter is held at zero in IDLE so it starts fresh on every REQ entry.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == IDLE)
        wait_q <= '0;
      else if (!dbus_ack_i)
        wait_q <= wait_q + 1'b1;
      if (tmo)
        err_q <= 1'b1;
    end
  end
`else
  assign tmo   = 1'b0;
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          state_d = REQ;
          stall   = 1'b1;
        end
      end
      REQ: begin
        if (dbus_ack_i | tmo) state_d = IDLE;
        else                  stall   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Gated by reset so an abandoned request cannot hold the pipeline.
  assign stall_o = stall & rst_n_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dbus_req_o   <= 1'b0;
      dbus_we_o    <= 1'b0;
      dbus_addr_o  <= '0;
      dbus_wdata_o <= '0;
    end else if (state_q == IDLE && acc) begin
      dbus_req_o   <= 1'b1;
      dbus_we_o    <= ram_we_i;
      dbus_addr_o  <= {aluc_i[31:2], 2'b00};
      dbus_wdata_o <= rD2_i;
    end else if (state_q == REQ && (dbus_ack_i || tmo)) begin
      dbus_req_o   <= 1'b0;
    end
  end

  assign wb_data = is_load ? (tmo ? '0 : dbus_rdata_i) : wD_i;

  reg_mem_wb u_reg_mem_wb (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .bubble_i   (stall_o),
    .valid_i    (valid_i),
    .rf_we_i    (rf_we_i),
    .wR_i       (wR_i),
    .wD_i       (wb_data),
    .wb_valid_o (wb_valid_o),
    .wb_rf_we_o (wb_rf_we_o),
    .wb_wR_o    (wb_wR_o),
    .wb_wD_o    (wb_wD_o)
  );

endmodule
